// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// PC_FETCH_MISALIGN_TRAP_EN adds the FAULT state for misaligned redirects.
package fetch_pkg;

    localparam int                INST_W   = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0]       PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        , ST_FAULT
`endif
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch address: sequential increment with wrap, or a redirect target,
// always kept 4-byte aligned and inside the instruction memory window.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int MEM_BYTES = 32
) (
    input  logic [31:0] pc_i,
    input  logic        advance_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] next_pc_o
);

    localparam logic [31:0] ADDR_MASK  = 32'(MEM_BYTES - 1);
    localparam logic [31:0] ALIGN_MASK = ~(PC_STEP - 32'd1);

    logic [31:0] pc_inc;
    logic [31:0] redirect_tgt;

    // MEM_BYTES is a power of two, so masking gives the modulo wrap.
    assign pc_inc       = (pc_i + PC_STEP) & ADDR_MASK;
    assign redirect_tgt = redirect_pc_i & ADDR_MASK & ALIGN_MASK;

    assign next_pc_o = redirect_valid_i ? redirect_tgt
                     : advance_i        ? pc_inc
                     :                    pc_i;

endmodule

// File: rtl/pc_fetch.sv
// Single-stage instruction fetch with decode back-pressure and redirect flush.
// Define PC_FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into FAULT.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [31:0]       pc,
    input  logic [INST_W-1:0] inst_code,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [31:0]       if_pc,
    output logic              misalign_fault
);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic [31:0]       if_pc_q, if_pc_d;
    logic [31:0]       next_pc;
    logic              advance;
    logic              redirect_taken;

    // A slot opens when the output register is empty or decode drains it.
    assign advance = ((state_q == ST_RUN) || (state_q == ST_HOLD)) &&
                     (!if_valid_q || id_ready);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic redirect_misaligned;

    assign redirect_taken      = redirect_valid && (state_q != ST_FAULT);
    assign redirect_misaligned = |redirect_pc[1:0];
    assign fault_d             = fault_q | (redirect_taken & redirect_misaligned);
    assign misalign_fault      = fault_q;

    always_ff @(posedge clk) begin
        if (!reset) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end
`else
    assign redirect_taken = redirect_valid;
    assign misalign_fault = 1'b0;
`endif

    fetch_next_pc #(
        .MEM_BYTES (MEM_BYTES)
    ) u_next_pc (
        .pc_i             (pc_q),
        .advance_i        (advance),
        .redirect_valid_i (redirect_taken),
        .redirect_pc_i    (redirect_pc),
        .next_pc_o        (next_pc)
    );

    // NOTE: every output of this block gets a hold default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;

        unique case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN, ST_HOLD: begin
                if (advance) begin
                    state_d    = ST_RUN;
                    pc_d       = next_pc;
                    if_valid_d = 1'b1;
                    if_inst_d  = inst_code;
                    if_pc_d    = pc_q;
                end else begin
                    state_d = ST_HOLD;
                end
            end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_IDLE;
        endcase

        // Redirect beats both advance and stall; the held word is dropped.
        if (redirect_taken) begin
            state_d    = ST_RUN;
            pc_d       = next_pc;
            if_valid_d = 1'b0;
            if_inst_d  = if_inst_q;
            if_pc_d    = if_pc_q;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            if (redirect_misaligned) begin
                state_d = ST_FAULT;
                pc_d    = pc_q;
            end
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_inst_q  <= NOP_INST;
            if_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign pc       = pc_q;
    assign if_valid = if_valid_q;
    assign if_inst  = if_inst_q;
    assign if_pc    = if_pc_q;

endmodule
